// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath (window feeder and conv layer).
// Latency: n/a (constants, types and a pure index function).
// Backpressure: n/a.
package conv_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int DATA_WIDTH  = 16;
  localparam int WIN_ELEMS   = KERNEL_SIZE * KERNEL_SIZE;

  // Window feeder control states
  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,  // accepting pixels
    ST_ISSUE  = 2'd1,  // presenting a completed window for one cycle
    ST_WAIT   = 2'd2   // conv stage owns the window until conv_done
  } win_state_t;

  // Flat element index of (channel c, window row r, window column k) on the packed window bus
  function automatic int win_idx(input int c, input int r, input int k);
    return c * WIN_ELEMS + r * KERNEL_SIZE + k;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of multi-channel pixels: combinational read and registered write at the same column.
// Latency: read is combinational; a write becomes visible on the cycle after wr_en.
// Backpressure: none; the owner decides when to write via wr_en.
module conv_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 192
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Old contents stay readable at addr until the edge that overwrites them
  assign rd_dat = mem[addr];

  // Row storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Builds 3x3 x CHANNELS valid-mode windows from a raster pixel stream and hands each to the conv stage.
// Latency: window_out/start_conv valid the cycle after the completing pixel is accepted.
// Backpressure: pix_ready drops while a window is issued/outstanding and returns the cycle after conv_done.
module conv_window_buffer #(
  parameter int CHANNELS    = 12,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic                            pix_sof,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  pix_data,
  output logic [CHANNELS*9*DATA_WIDTH-1:0] window_out,
  output logic                            start_conv,
  input  logic                            conv_done,
  output logic [$clog2(IMG_H)-1:0]        win_row,
  output logic [$clog2(IMG_W)-1:0]        win_col,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err_done
);

  import conv_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = CHANNELS * DATA_WIDTH;

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("conv_window_buffer only supports KERNEL_SIZE = 3");
  end

  win_state_t     state, state_nxt;
  logic [XW-1:0]  x, ex;
  logic [YW-1:0]  y, ey;
  logic [PW-1:0]  win [3][3];
  logic [PW-1:0]  lb0_rd_dat, lb1_rd_dat;
  logic           accept, complete, at_last_col, at_last_row;
  logic           last_win;

  // A pixel carrying sof is placed at (0,0) regardless of where the counters are
  assign ex          = pix_sof ? '0 : x;
  assign ey          = pix_sof ? '0 : y;
  assign accept      = pix_valid && (state == ST_STREAM);
  assign at_last_col = (ex == XW'(IMG_W - 1));
  assign at_last_row = (ey == YW'(IMG_H - 1));
  assign complete    = accept && (ey >= YW'(2)) && (ex >= XW'(2));

  // lb0 holds the previous row, lb1 the row before it; both shift down on every accept
  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb0 (
    .clk    (clk),
    .addr   (ex),
    .wr_en  (accept),
    .wr_dat (pix_data),
    .rd_dat (lb0_rd_dat)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
    .clk    (clk),
    .addr   (ex),
    .wr_en  (accept),
    .wr_dat (lb0_rd_dat),
    .rd_dat (lb1_rd_dat)
  );

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_STREAM;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    start_conv = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_STREAM: begin
        pix_ready = 1'b1;
        if (complete) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        start_conv = 1'b1;
        busy       = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (conv_done) state_nxt = ST_STREAM;
      end
      default: state_nxt = ST_STREAM;
    endcase
  end

  // Raster position of the next pixel; wraps to (0,0) after the last pixel of a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        x <= '0;
        y <= at_last_row ? '0 : ey + YW'(1);
      end else begin
        x <= ex + XW'(1);
        y <= ey;
      end
    end
  end

  // 3x3 shift window: column 0 is oldest, row 0 is the oldest image row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          win[r][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd_dat;
      win[1][2] <= lb0_rd_dat;
      win[2][2] <= pix_data;
    end
  end

  // Window centre, end-of-frame tracking and protocol error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_row    <= '0;
      win_col    <= '0;
      last_win   <= 1'b0;
      frame_done <= 1'b0;
      err_done   <= 1'b0;
    end else begin
      if (complete) begin
        win_row  <= ey - YW'(1);
        win_col  <= ex - XW'(1);
        last_win <= at_last_row && at_last_col;
      end
      frame_done <= (state == ST_WAIT) && conv_done && last_win;
      if (conv_done && (state != ST_WAIT)) err_done <= 1'b1;
    end
  end

  // Flatten the window onto the conv stage bus, element (c,r,k) at win_idx(c,r,k)
  always_comb begin
    window_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          window_out[win_idx(c, r, k)*DATA_WIDTH +: DATA_WIDTH] = win[r][k][c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomized bench for conv_window_buffer against an image-array reference model.
// Latency: checks start_conv the cycle after a completing accept and busy release the cycle after conv_done.
// Backpressure: pix_valid and conv_done delay are randomized; pix_ready is checked every cycle.
module tb_conv_window_buffer;

  localparam int CH = 12;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef logic [CH*DW-1:0]   pix_t;
  typedef logic [CH*9*DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_valid, pix_ready, pix_sof, conv_done;
  pix_t          pix_data;
  win_t          window_out;
  logic          start_conv, busy, frame_done, err_done;
  logic [YW-1:0] win_row;
  logic [XW-1:0] win_col;

  conv_window_buffer #(
    .CHANNELS(CH), .KERNEL_SIZE(3), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .window_out (window_out),
    .start_conv (start_conv),
    .conv_done  (conv_done),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done),
    .err_done   (err_done)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: the current frame as a plain image, plus expected windows in issue order
  pix_t img [H][W];
  int   mx, my;
  win_t exp_win[$];
  int   exp_row[$];
  int   exp_col[$];
  bit   exp_last[$];
  bit   busy_exp;
  bit   err_exp;
  pix_t stim_dat[$];
  bit   stim_sof[$];
  int   nstart;
  win_t first_win;

  function automatic pix_t mk_pix(input int y, input int x);
    pix_t p;
    for (int c = 0; c < CH; c++) p[c*DW +: DW] = 16'(c*256 + 16*y + x);
    return p;
  endfunction

  function automatic pix_t rnd_pix();
    pix_t p;
    for (int c = 0; c < CH; c++) p[c*DW +: DW] = 16'($urandom());
    return p;
  endfunction

  task automatic push_frame(input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        stim_dat.push_back(rnd ? rnd_pix() : mk_pix(y, x));
        stim_sof.push_back(y == 0 && x == 0);
      end
  endtask

  task automatic push_partial(input int n);
    for (int i = 0; i < n; i++) begin
      stim_dat.push_back(mk_pix(i / W, i % W));
      stim_sof.push_back(i == 0);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0;
    exp_win.delete(); exp_row.delete(); exp_col.delete(); exp_last.delete();
    stim_dat.delete(); stim_sof.delete();
    busy_exp = 0; err_exp = 0;
  endfunction

  // Place the pixel in the image; a window exists whenever a full 3x3 neighbourhood ends at this pixel
  function automatic bit model_accept(input pix_t d, input bit sof);
    bit   done = 0;
    win_t w;
    if (sof) begin mx = 0; my = 0; end
    img[my][mx] = d;
    if (my >= 2 && mx >= 2) begin
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++)
            w[(c*9 + r*3 + k)*DW +: DW] = img[my-2+r][mx-2+k][c*DW +: DW];
      exp_win.push_back(w);
      exp_row.push_back(my - 1);
      exp_col.push_back(mx - 1);
      exp_last.push_back(my == H-1 && mx == W-1);
      done = 1;
    end
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    return done;
  endfunction

  // Streams the queued pixels, answers each window with conv_done after a random delay, checks every cycle
  task automatic run_stream(input int vpct, input int dmin, input int dmax, input bit stop_on_issue);
    int   cyc = 0;
    int   dcnt = 0;
    bit   issue_exp = 0;
    bit   issued;
    bit   fd_exp = 0;
    bit   cur_last = 0;
    win_t ew;
    int   er, ec;
    while ((stim_dat.size() > 0 || busy_exp || fd_exp) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      vectors++; if (start_conv !== issue_exp) begin miscompares++; $display("FAIL start_conv: got %0b want %0b (cycle %0d)", start_conv, issue_exp, cyc); end
      vectors++; if (busy !== busy_exp) begin miscompares++; $display("FAIL busy: got %0b want %0b (cycle %0d)", busy, busy_exp, cyc); end
      vectors++; if (pix_ready !== !busy_exp) begin miscompares++; $display("FAIL pix_ready: got %0b want %0b (cycle %0d)", pix_ready, !busy_exp, cyc); end
      vectors++; if (frame_done !== fd_exp) begin miscompares++; $display("FAIL frame_done: got %0b want %0b (cycle %0d)", frame_done, fd_exp, cyc); end
      vectors++; if (err_done !== err_exp) begin miscompares++; $display("FAIL err_done: got %0b want %0b (cycle %0d)", err_done, err_exp, cyc); end
      if (start_conv === 1'b1) begin
        nstart++;
        if (nstart == 1) first_win = window_out;
      end
      issued = issue_exp;
      if (issue_exp) begin
        ew = exp_win.pop_front(); er = exp_row.pop_front(); ec = exp_col.pop_front();
        cur_last = exp_last.pop_front();
        vectors++; if (window_out !== ew) begin miscompares++; $display("FAIL window_out: got %0h want %0h", window_out, ew); end
        vectors++; if (win_row !== YW'(er)) begin miscompares++; $display("FAIL win_row: got %0d want %0d", win_row, er); end
        vectors++; if (win_col !== XW'(ec)) begin miscompares++; $display("FAIL win_col: got %0d want %0d", win_col, ec); end
        issue_exp = 0;
      end
      fd_exp = 0;
      conv_done = 0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin conv_done = 1; busy_exp = 0; fd_exp = cur_last; end
      end
      if (issued) dcnt = $urandom_range(dmax, dmin);
      if (stop_on_issue && issued) break;
      pix_valid = 0; pix_sof = 0; pix_data = rnd_pix();
      if (stim_dat.size() > 0 && $urandom_range(99, 0) < vpct) begin
        pix_valid = 1; pix_data = stim_dat[0]; pix_sof = stim_sof[0];
        if (pix_ready === 1'b1) begin
          if (model_accept(stim_dat[0], stim_sof[0])) begin issue_exp = 1; busy_exp = 1; end
          void'(stim_dat.pop_front()); void'(stim_sof.pop_front());
        end
      end
    end
    pix_valid = 0; pix_sof = 0; conv_done = 0;
    vectors++; if (cyc >= 4000) begin miscompares++; $display("FAIL stream_timeout: got %0d cycles want < 4000", cyc); end
  endtask

  task automatic test_reset();
    rst_n = 0; pix_valid = 0; pix_sof = 0; conv_done = 0; pix_data = '0;
    repeat (3) @(negedge clk);
    vectors++; if (start_conv !== 1'b0) begin miscompares++; $display("FAIL reset_start_conv: got %0b want 0", start_conv); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    vectors++; if (err_done !== 1'b0) begin miscompares++; $display("FAIL reset_err_done: got %0b want 0", err_done); end
    vectors++; if (window_out !== '0) begin miscompares++; $display("FAIL reset_window: got %0h want 0", window_out); end
    vectors++; if (win_row !== '0 || win_col !== '0) begin miscompares++; $display("FAIL reset_centre: got %0d,%0d want 0,0", win_row, win_col); end
    rst_n = 1;
    @(negedge clk);
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL reset_pix_ready: got %0b want 1", pix_ready); end
    model_reset();
  endtask

  task automatic test_basic();
    int ref_first [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    nstart = 0;
    push_frame(0);
    run_stream(100, 3, 3, 0);
    vectors++; if (nstart != 4) begin miscompares++; $display("FAIL basic_pulses: got %0d want 4", nstart); end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (first_win[i*DW +: DW] !== 16'(ref_first[i]) || first_win[(99+i)*DW +: DW] !== 16'(11*256 + ref_first[i])) begin
        miscompares++;
        $display("FAIL basic_first_window[%0d]: got %0h/%0h want %0h/%0h", i, first_win[i*DW +: DW],
                 first_win[(99+i)*DW +: DW], ref_first[i], 11*256 + ref_first[i]);
      end
    end
  endtask

  task automatic test_random_valid();
    nstart = 0;
    push_frame(0); push_frame(0);
    run_stream(50, 1, 6, 0);
    vectors++; if (nstart != 8) begin miscompares++; $display("FAIL random_valid_pulses: got %0d want 8", nstart); end
  endtask

  task automatic test_random_data();
    nstart = 0;
    push_frame(1); push_frame(1);
    run_stream(70, 1, 4, 0);
    vectors++; if (nstart != 8) begin miscompares++; $display("FAIL random_data_pulses: got %0d want 8", nstart); end
  endtask

  task automatic test_sof_restart();
    nstart = 0;
    push_partial(2*W + 3);
    push_frame(0);
    run_stream(80, 2, 4, 0);
    vectors++; if (nstart != 5) begin miscompares++; $display("FAIL sof_pulses: got %0d want 5", nstart); end
  endtask

  task automatic test_err_done();
    win_t wsave;
    @(negedge clk);
    wsave = window_out;
    conv_done = 1;
    @(negedge clk);
    conv_done = 0;
    err_exp = 1;
    vectors++; if (err_done !== 1'b1) begin miscompares++; $display("FAIL err_set: got %0b want 1", err_done); end
    vectors++; if (busy !== 1'b0 || pix_ready !== 1'b1 || start_conv !== 1'b0) begin miscompares++; $display("FAIL err_state: got busy=%0b rdy=%0b start=%0b want 0/1/0", busy, pix_ready, start_conv); end
    vectors++; if (window_out !== wsave) begin miscompares++; $display("FAIL err_window: got %0h want %0h", window_out, wsave); end
    repeat (4) @(negedge clk);
    vectors++; if (err_done !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %0b want 1", err_done); end
    nstart = 0;
    push_frame(1);
    run_stream(90, 1, 3, 0);
    vectors++; if (nstart != 4) begin miscompares++; $display("FAIL err_after_pulses: got %0d want 4", nstart); end
  endtask

  task automatic test_reset_in_wait();
    push_frame(0);
    run_stream(100, 3, 3, 1);
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wait_busy: got %0b want 1", busy); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    vectors++; if (busy !== 1'b0 || pix_ready !== 1'b1 || start_conv !== 1'b0) begin miscompares++; $display("FAIL wait_reset_state: got busy=%0b rdy=%0b start=%0b want 0/1/0", busy, pix_ready, start_conv); end
    vectors++; if (window_out !== '0 || err_done !== 1'b0) begin miscompares++; $display("FAIL wait_reset_clear: got win=%0h err=%0b want 0/0", window_out, err_done); end
    model_reset();
    nstart = 0;
    push_frame(0);
    run_stream(60, 1, 5, 0);
    vectors++; if (nstart != 4) begin miscompares++; $display("FAIL after_reset_pulses: got %0d want 4", nstart); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_valid();
    test_random_data();
    test_sof_restart();
    test_err_done();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
